// File: rtl/bcd_digit_scan_pkg.sv
// ------------------------------------------------------------------
// bcd_digit_scan_pkg : shared display codes and default sizing
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package bcd_digit_scan_pkg;
  localparam logic [3:0] BLANK_CODE      = 4'hF;
  localparam logic [3:0] BCD_MAX         = 4'd9;
  localparam int         DEF_N_DIGITS    = 4;
  localparam int         DEF_REFRESH_DIV = 50000;
endpackage

`default_nettype wire

// File: rtl/bcd_digit_scan_refresh_prescaler.sv
// ------------------------------------------------------------------
// refresh_prescaler : free-running divider, one-cycle tick every DIV clocks
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module refresh_prescaler
  import bcd_digit_scan_pkg::*;
#(
  parameter int DIV = DEF_REFRESH_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // DIV = 1 keeps the counter pinned at 0, so tick is asserted every cycle.
  assign tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/bcd_digit_scan.sv
// ------------------------------------------------------------------
// bcd_digit_scan : multiplexed BCD digit scanner with LZ blanking
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module bcd_digit_scan
  import bcd_digit_scan_pkg::*;
#(
  parameter int N_DIGITS    = DEF_N_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       digits_in,
  input  logic                        blank_lz,
  output logic [3:0]                  bcd_out,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        err
);

  localparam int            IW         = $clog2(N_DIGITS);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] r_shadow;
  logic [IW-1:0]         r_idx;
  logic                  w_tick;
  logic [3:0]            w_digit;
  logic [N_DIGITS-1:0]   w_an_lit;
  logic [N_DIGITS-1:0]   w_upper_zero;
  logic                  w_load_err;
  logic                  w_blank;
  logic                  w_invalid;
  logic                  w_run_zero;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // w_upper_zero[i] is set when digits i..N-1 of the shadow word are all zero.
  always_comb begin
    w_digit      = '0;
    w_an_lit     = '1;
    w_upper_zero = '0;
    w_load_err   = 1'b0;
    w_run_zero   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_run_zero      = w_run_zero && (r_shadow[4*i +: 4] == 4'd0);
      w_upper_zero[i] = w_run_zero;
      w_load_err      = w_load_err || (digits_in[4*i +: 4] > BCD_MAX);
      if (r_idx == IW'(i)) begin
        w_digit     = r_shadow[4*i +: 4];
        w_an_lit[i] = 1'b0;
      end
    end
  end

  assign w_blank   = blank_lz && (r_idx != '0) && w_upper_zero[r_idx];
  assign w_invalid = (w_digit > BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_idx     <= '0;
      err       <= 1'b0;
      bcd_out   <= 4'h0;
      an        <= ~{{(N_DIGITS-1){1'b0}}, 1'b1};
      digit_idx <= '0;
    end else begin
      if (load) begin
        r_shadow <= digits_in;
        err      <= w_load_err;
      end
      if (w_tick) begin
        r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + IW'(1);
      end
      // Slot outputs follow the pre-edge shadow/idx, so an and bcd_out switch together.
      digit_idx <= r_idx;
      if (w_blank || w_invalid) begin
        bcd_out <= BLANK_CODE;
        an      <= '1;
      end else begin
        bcd_out <= w_digit;
        an      <= w_an_lit;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/bcd_digit_scan.md
# bcd_digit_scan

Time-multiplexing scan controller for an N-digit common-anode seven-segment display. It sits directly upstream of the BCD-to-seven-segment decoder: it latches a packed multi-digit BCD word, steps through the digits at a programmable refresh rate, and presents one 4-bit BCD code to the decoder plus the matching active-low anode enable each slot. It also provides leading-zero blanking and flags invalid (>9) digits. The block drives code 4'hF for blanked slots, which the decoder renders as all segments off.

## Interface
- N_DIGITS, 4: number of display digits, ≥2.
- REFRESH_DIV, 50000: clk cycles each digit is displayed, ≥1.
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- load  in  1  single-cycle strobe that latches digits_in.
- digits_in  in  4*N_DIGITS  packed BCD word. Digit 0 is bits [3:0] and is the least significant.
- blank_lz  in  1  leading-zero blanking enable. Sampled every cycle.
- bcd_out  out  4  BCD code to the decoder. 4'hF means blank.
- an  out  N_DIGITS  anode enables, active-low, one-cold.
- digit_idx  out  $clog2(N_DIGITS)  index of the digit currently displayed.
- err  out  1  high while the latched word contains any digit >9.

## Operation
- **Reset state:**
  - shadow register = 0, prescaler = 0, idx = 0.
  - Outputs: bcd_out = 4'h0, an = ~1 (only bit 0 low), digit_idx = 0, err = 0.
  - While rst is high, load is ignored.
- **Load:** on a clk edge with load = 1, shadow ← digits_in. err ← OR over all digits of (digit > 9).
- **Prescaler:** counts 0 … REFRESH_DIV−1 and then wraps. The terminal count produces a one-cycle tick. REFRESH_DIV = 1 gives a tick every cycle.
- **Digit index:** on each tick, idx advances by 1 and wraps from N_DIGITS−1 to 0. Scan order is digit 0, 1, …, N−1.
- **Slot content, computed from shadow and idx:**
  - Digit d = shadow[4*idx +: 4].
  - Blank if blank_lz = 1, idx ≠ 0, and every shadow digit from idx up to N−1 is 0. Digit 0 is never leading-zero blanked.
  - Invalid if d > 9.
  - If blank or invalid: bcd_out = 4'hF and an = all ones (no digit lit).
  - Otherwise: bcd_out = d, and an has only bit idx low.
- **Simultaneous events:**
  - load and tick on the same edge: both take effect. The new idx is shown using the new shadow.
  - rst has priority over load and tick.
- **Reset mid-scan:** the state returns to reset values on the next edge, and the scan restarts at digit 0.

## Timing
- bcd_out, an, digit_idx and err are all registered.
- Slot content is registered from the current shadow and idx. Outputs therefore reflect a shadow or idx change one cycle after the edge that changed them:
  - load at edge k → shadow updated at k → bcd_out/an updated at k+1.
  - err is updated at edge k.
- A tick at edge k → idx updated at k → digit_idx, bcd_out and an updated at k+1.
- Each digit is presented for exactly REFRESH_DIV cycles. A full frame is N_DIGITS × REFRESH_DIV cycles.
- The an change and the bcd_out change occur on the same edge. There is no partial-slot glitch.
- A blank_lz change is visible on outputs one cycle later.

## Structure
- The shared display package holds:
  - BLANK_CODE = 4'hF.
  - BCD_MAX = 4'd9.
  - Default N_DIGITS and REFRESH_DIV.
- One sub-module, refresh_prescaler: parameter DIV; ports clk, rst, tick. The top block contains the shadow register, idx counter, blanking/validity logic and output registers.

## Test plan
Parameters for all scenarios: N_DIGITS = 4, REFRESH_DIV = 4.
- **Reset:** hold rst high for 2 cycles, then release → an = 4'b1110, bcd_out = 0, digit_idx = 0, err = 0. First idx change occurs 4 cycles after release.
- **Basic scan:** load 16'h1234 with blank_lz = 0 → bcd_out shows 4, 3, 2, 1, each for 4 cycles, with an = 1110, 1101, 1011, 0111. The sequence then wraps to 4 / 1110.
- **Leading-zero blanking:** with blank_lz = 1:
  - load 16'h0045 → slots 2 and 3 give bcd_out = F, an = 1111; slots 0 and 1 show 5 and 4.
  - load 16'h0000 → digit 0 shows 0, digits 1–3 are blank.
  - load 16'h0405 → digit 2 shows 4, digit 1 shows 0 (not blanked), digit 3 is blank.
- **Invalid digit:** load 16'h12A4 → err = 1 at the load edge; slot 1 gives bcd_out = F, an = 1111; the other digits are normal. Then load 16'h1234 → err = 0.
- **Load coincident with tick:** load 16'h5678 on the edge where idx goes 1→2 → the next cycle shows bcd_out = 6, an = 1011.
- **Reset mid-scan:** assert rst for one cycle while idx = 2 → the next edge gives idx = 0, shadow = 0. A load in that same cycle is discarded.
